// File: rtl/alu_acc_pkg.sv
// Shared opcodes, FSM state encoding, flag-bit positions and command layout for the ALU accumulator controller.
// The optional sticky-overflow output is selected by ALU_ACC_STICKY_EN.
package alu_acc_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADC  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SBC  = 4'd3;
  localparam logic [3:0] OP_INC  = 4'd4;
  localparam logic [3:0] OP_DEC  = 4'd5;
  localparam logic [3:0] OP_NEG  = 4'd6;
  localparam logic [3:0] OP_PASA = 4'd7;
  localparam logic [3:0] OP_PASB = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;
  localparam logic [3:0] OP_OR   = 4'd10;
  localparam logic [3:0] OP_NOT  = 4'd11;
  localparam logic [3:0] OP_XOR  = 4'd12;

  // Bit positions inside res_flags = {carry, overflow, zero, negative}
  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  localparam int CMD_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  typedef struct packed {
    logic       load;
    logic [3:0] op;
    logic [3:0] data;
  } cmd_t;

  function automatic logic [3:0] load_flags(input logic [3:0] d);
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = (d == 4'd0);
    f[FLAG_N] = d[3];
    return f;
  endfunction

endpackage

// File: rtl/alu_acc_ctrl_if.sv
// Command and result channels of the ALU accumulator controller (valid/ready on both).
// master = command source / result sink, slave = the controller.
interface alu_acc_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [3:0] cmd_data;
  logic       cmd_load;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic [3:0] res_flags;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_load, res_ready,
    input  cmd_ready, res_valid, res_data, res_flags
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_load, res_ready,
    output cmd_ready, res_valid, res_data, res_flags
  );
endinterface

// File: rtl/alu_acc_cmd_fifo.sv
// Command FIFO: registered pointers, one-cycle write-to-read latency; push ignored when full, pop ignored when empty.
// Backpressure: full_o drops the upstream ready; no pass-through when full.
module alu_acc_cmd_fifo
  import alu_acc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CMD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push, pop;

  assign full_o    = (count_q == CNT_FULL);
  assign empty_o   = (count_q == '0);
  assign push      = push_i & ~full_o;
  assign pop       = pop_i & ~empty_o;
  assign pop_dat_o = mem_q[rd_ptr_q];

  // Power-of-two depth lets the pointers wrap by natural overflow
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/alu_acc_ctrl.sv
// Accumulator controller feeding an external 4-bit ALU; result valid 2 edges after cmd accept, one cmd per 3 cycles.
// Backpressure: WB holds the result until res_ready; cmd_ready = !fifo_full. Optional sticky_ovf_o under ALU_ACC_STICKY_EN.
module alu_acc_ctrl
  import alu_acc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_acc_ctrl_if.slave        bus,
  output logic [3:0]           alu_a_o,
  output logic [3:0]           alu_b_o,
  output logic [3:0]           alu_op_o,
  input  logic [3:0]           alu_result_i,
  input  logic                 alu_carry_i,
  input  logic                 alu_overflow_i,
  input  logic                 alu_zero_i,
  input  logic                 alu_negative_i,
  output logic [3:0]           acc_o
`ifdef ALU_ACC_STICKY_EN
  ,
  output logic                 sticky_ovf_o
`endif
);

  state_t     state_q, state_d;
  cmd_t       cmd_q, cmd_d;
  cmd_t       push_cmd, fifo_head;
  logic [3:0] acc_q, acc_d;
  logic [3:0] res_data_q, res_data_d;
  logic [3:0] res_flags_q, res_flags_d;
  logic       res_valid_q, res_valid_d;
  logic [3:0] alu_flags;
  logic       fifo_full, fifo_empty, pop;

  assign push_cmd = '{load: bus.cmd_load, op: bus.cmd_op, data: bus.cmd_data};

  alu_acc_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (bus.cmd_valid),
    .push_dat_i (push_cmd),
    .pop_i      (pop),
    .pop_dat_o  (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign alu_flags[FLAG_C] = alu_carry_i;
  assign alu_flags[FLAG_V] = alu_overflow_i;
  assign alu_flags[FLAG_Z] = alu_zero_i;
  assign alu_flags[FLAG_N] = alu_negative_i;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    acc_d       = acc_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    res_valid_d = res_valid_q;
    pop         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cmd_d   = fifo_head;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cmd_q.load) begin
          acc_d       = cmd_q.data;
          res_data_d  = cmd_q.data;
          res_flags_d = load_flags(cmd_q.data);
        end else begin
          acc_d       = alu_result_i;
          res_data_d  = alu_result_i;
          res_flags_d = alu_flags;
        end
        res_valid_d = 1'b1;
        state_d     = ST_WB;
      end
      ST_WB: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      acc_q       <= '0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      acc_q       <= acc_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
      res_valid_q <= res_valid_d;
    end
  end

`ifdef ALU_ACC_STICKY_EN
  logic sticky_q, sticky_d;

  // A load is the only way to clear; it never reports overflow itself
  always_comb begin
    sticky_d = sticky_q;
    if (state_q == ST_EXEC) begin
      if (cmd_q.load)          sticky_d = 1'b0;
      else if (alu_overflow_i) sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= 1'b0;
    else        sticky_q <= sticky_d;
  end

  assign sticky_ovf_o = sticky_q;
`endif

  assign bus.cmd_ready = ~fifo_full;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_flags = res_flags_q;
  assign alu_a_o       = acc_q;
  assign alu_b_o       = cmd_q.data;
  assign alu_op_o      = cmd_q.op;
  assign acc_o         = acc_q;

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// Directed bench for alu_acc_ctrl with a behavioural 4-bit ALU; flags are {carry, overflow, zero, negative}.
module tb_alu_acc_ctrl;
  import alu_acc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] alu_a, alu_b, alu_op, alu_result, acc;
  logic       alu_carry, alu_overflow, alu_zero, alu_negative;
`ifdef ALU_ACC_STICKY_EN
  logic       sticky_ovf;
`endif
  int         pass_cnt = 0;
  int         fail_cnt = 0;
  int         chk_cnt  = 0;

  alu_acc_ctrl_if bus ();

  alu_acc_ctrl #(.FIFO_DEPTH(4)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .alu_a_o        (alu_a),
    .alu_b_o        (alu_b),
    .alu_op_o       (alu_op),
    .alu_result_i   (alu_result),
    .alu_carry_i    (alu_carry),
    .alu_overflow_i (alu_overflow),
    .alu_zero_i     (alu_zero),
    .alu_negative_i (alu_negative),
    .acc_o          (acc)
`ifdef ALU_ACC_STICKY_EN
    ,
    .sticky_ovf_o   (sticky_ovf)
`endif
  );

  always #5 clk = ~clk;

  // Downstream ALU: ADD sets carry/overflow, logic ops clear them
  always_comb begin
    logic [4:0] sum;
    sum          = {1'b0, alu_a} + {1'b0, alu_b};
    alu_result   = alu_b;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_op)
      OP_ADD: begin
        alu_result   = sum[3:0];
        alu_carry    = sum[4];
        alu_overflow = (alu_a[3] == alu_b[3]) && (sum[3] != alu_a[3]);
      end
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_XOR:  alu_result = alu_a ^ alu_b;
      default: alu_result = alu_b;
    endcase
    alu_zero     = (alu_result == 4'd0);
    alu_negative = alu_result[3];
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns #1 after the accepting edge
  task automatic push(input logic ld, input logic [3:0] op, input logic [3:0] d);
    int n;
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = ld;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("push_ready", {7'd0, bus.cmd_ready}, 8'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag, input logic [3:0] exp_d, input logic [3:0] exp_f);
    int n;
    bus.res_ready = 1'b1;
    n = 0;
    while (!bus.res_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_valid"}, {7'd0, bus.res_valid}, 8'd1);
    check({tag, "_data"},  {4'd0, bus.res_data},  {4'd0, exp_d});
    check({tag, "_flags"}, {4'd0, bus.res_flags}, {4'd0, exp_f});
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  initial begin
    int n;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_load  = 1'b0;
    bus.cmd_op    = 4'd0;
    bus.cmd_data  = 4'd0;
    bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", {7'd0, bus.cmd_ready}, 8'd1);
    check("rst_res_valid", {7'd0, bus.res_valid}, 8'd0);
    check("rst_acc",       {4'd0, acc},           8'd0);
    check("rst_res_data",  {4'd0, bus.res_data},  8'd0);
    check("rst_res_flags", {4'd0, bus.res_flags}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Load 3 with latency probe: valid must appear after the 2nd edge
    bus.res_ready = 1'b1;
    push(1'b1, OP_ADD, 4'd3);
    check("lat_e0", {7'd0, bus.res_valid}, 8'd0);
    @(posedge clk); #1;
    check("lat_e1", {7'd0, bus.res_valid}, 8'd0);
    @(posedge clk); #1;
    check("lat_e2",      {7'd0, bus.res_valid}, 8'd1);
    check("ld3_data",    {4'd0, bus.res_data},  8'd3);
    check("ld3_flags",   {4'd0, bus.res_flags}, 8'h0);
    check("ld3_acc",     {4'd0, acc},           8'd3);
    @(posedge clk); #1;
    bus.res_ready = 1'b0;

    push(1'b0, OP_ADD, 4'd5);
    wait_res("add5", 4'd8, 4'b0101);
    check("add5_acc", {4'd0, acc}, 8'd8);

    push(1'b1, OP_ADD, 4'd15);
    wait_res("ld15", 4'd15, 4'b0001);
    push(1'b0, OP_ADD, 4'd1);
    wait_res("wrap", 4'd0, 4'b1010);
    check("wrap_acc", {4'd0, acc}, 8'd0);

    push(1'b1, OP_ADD, 4'd12);
    wait_res("ld12", 4'd12, 4'b0001);
    push(1'b0, OP_AND, 4'd10);
    wait_res("and10", 4'd8, 4'b0001);
    push(1'b0, OP_XOR, 4'd8);
    wait_res("xor8", 4'd0, 4'b0010);

    // Stalled result: 4 in FIFO plus 1 in the command register
    bus.res_ready = 1'b0;
    push(1'b1, OP_ADD, 4'd1);
    push(1'b0, OP_ADD, 4'd1);
    push(1'b0, OP_ADD, 4'd1);
    push(1'b0, OP_ADD, 4'd1);
    check("fill4_ready", {7'd0, bus.cmd_ready}, 8'd1);
    push(1'b0, OP_ADD, 4'd1);
    check("full_ready", {7'd0, bus.cmd_ready}, 8'd0);
    check("full_valid", {7'd0, bus.res_valid}, 8'd1);
    wait_res("q1", 4'd1, 4'b0000);
    wait_res("q2", 4'd2, 4'b0000);
    wait_res("q3", 4'd3, 4'b0000);
    wait_res("q4", 4'd4, 4'b0000);
    wait_res("q5", 4'd5, 4'b0000);
    check("q_acc",   {4'd0, acc},           8'd5);
    check("q_ready", {7'd0, bus.cmd_ready}, 8'd1);

    // Reset while stalled in WB with commands still queued
    push(1'b1, OP_ADD, 4'd9);
    push(1'b0, OP_ADD, 4'd2);
    push(1'b0, OP_ADD, 4'd3);
    n = 0;
    while (!bus.res_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("wb_reached", {7'd0, bus.res_valid}, 8'd1);
    check("wb_acc",     {4'd0, acc},           8'd9);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {7'd0, bus.res_valid},              8'd0);
    check("mid_rst_acc",   {4'd0, acc},                        8'd0);
    check("mid_rst_count", {5'd0, u_dut.u_fifo.count_q},       8'd0);
    check("mid_rst_ready", {7'd0, bus.cmd_ready},              8'd1);
    check("mid_rst_data",  {4'd0, bus.res_data},               8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle", {7'd0, bus.res_valid}, 8'd0);
    push(1'b0, OP_ADD, 4'd6);
    wait_res("post_rst", 4'd6, 4'b0000);
    check("post_rst_acc", {4'd0, acc}, 8'd6);

`ifdef ALU_ACC_STICKY_EN
    push(1'b1, OP_ADD, 4'd7);
    wait_res("st_ld7", 4'd7, 4'b0000);
    check("st_init", {7'd0, sticky_ovf}, 8'd0);
    push(1'b0, OP_ADD, 4'd1);
    wait_res("st_add1", 4'd8, 4'b0101);
    check("st_set", {7'd0, sticky_ovf}, 8'd1);
    push(1'b0, OP_ADD, 4'd0);
    wait_res("st_add0", 4'd8, 4'b0001);
    check("st_hold", {7'd0, sticky_ovf}, 8'd1);
    push(1'b1, OP_ADD, 4'd0);
    wait_res("st_ld0", 4'd0, 4'b0010);
    check("st_clr", {7'd0, sticky_ovf}, 8'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
